// File: rtl/rv_pkg.sv
// Shared RV32 constants, fetch FSM states and the IF/ID bundle.
package rv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FS_BOOT,
    FS_RUN,
    FS_HALT
  } fetch_state_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } if_id_t;

  function automatic logic [6:0] opcode_of(input logic [XLEN-1:0] i);
    return i[6:0];
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register; clear kills only the valid bit.
module if_id_reg
  import rv_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  input  logic   clr,
  input  if_id_t d,
  output if_id_t q
);

  if_id_t q_d;
  if_id_t q_q;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d.valid = 1'b0;
    end else if (en) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q.valid    <= 1'b0;
      q_q.instr    <= NOP_INSTR;
      q_q.pc       <= '0;
      q_q.pc_plus4 <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, BOOT/RUN/HALT control and IF/ID capture.
module fetch_stage
  import rv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            resume,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            id_valid,
  output logic [XLEN-1:0] id_instr,
  output logic [6:0]      id_opcode,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4,
  output logic            misalign,
  output logic            halted
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] pc_plus4;
  logic            redir;
  logic            fetch;
  logic            ifid_en;
  logic            ifid_clr;
  if_id_t          ifid_d;
  if_id_t          ifid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FS_BOOT;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  // BOOT ignores everything; it only exists to give one dead cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FS_BOOT: state_d = FS_RUN;
      FS_RUN: begin
        if (!redirect_valid && !stall &&
            opcode_of(imem_rdata) == OPC_SYSTEM) begin
          state_d = FS_HALT;
        end
      end
      FS_HALT: begin
        if (redirect_valid || resume) begin
          state_d = FS_RUN;
        end
      end
      default: state_d = FS_BOOT;
    endcase
  end

  always_comb begin
    pc_plus4   = pc_q + XLEN'(4);
    redir      = (state_q != FS_BOOT) && redirect_valid;
    fetch      = (state_q == FS_RUN) && !redirect_valid && !stall;
    pc_d       = pc_q;
    misalign_d = misalign_q;
    unique case (1'b1)
      redir: begin
        pc_d       = {redirect_target[XLEN-1:2], 2'b00};
        misalign_d = |redirect_target[1:0];
      end
      fetch:   pc_d = pc_plus4;
      default: pc_d = pc_q;
    endcase
    ifid_en        = fetch;
    ifid_clr       = redir || (state_q == FS_HALT);
    ifid_d.valid    = 1'b1;
    ifid_d.instr    = imem_rdata;
    ifid_d.pc       = pc_q;
    ifid_d.pc_plus4 = pc_plus4;
  end

  if_id_reg u_if_id (
    .clk (clk),
    .rst (rst),
    .en  (ifid_en),
    .clr (ifid_clr),
    .d   (ifid_d),
    .q   (ifid_q)
  );

  always_comb begin
    imem_addr   = pc_q;
    id_valid    = ifid_q.valid;
    id_instr    = ifid_q.instr;
    id_opcode   = opcode_of(ifid_q.instr);
    id_pc       = ifid_q.pc;
    id_pc_plus4 = ifid_q.pc_plus4;
    misalign    = misalign_q;
    halted      = (state_q == FS_HALT);
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a per-cycle reference model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        resume = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [6:0]  id_opcode;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        misalign;
  logic        halted;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  fetch_stage #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .resume          (resume),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .id_valid        (id_valid),
    .id_instr        (id_instr),
    .id_opcode       (id_opcode),
    .id_pc           (id_pc),
    .id_pc_plus4     (id_pc_plus4),
    .misalign        (misalign),
    .halted          (halted)
  );

  // ecall at 0x20; every other word is an OP-IMM tagged by its address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h20) return 32'h0000_0073;
    return {a[24:0], 7'b0010011};
  endfunction

  always_comb imem_rdata = mem_word(imem_addr);

  // reference model: 0 boot, 1 run, 2 halt
  int          m_mode = 0;
  logic [31:0] m_pc = '0;
  logic        m_v = 1'b0;
  logic [31:0] m_instr = 32'h13;
  logic [31:0] m_ipc = '0;
  logic [31:0] m_ipc4 = '0;
  logic        m_mis = 1'b0;

  task automatic model_step();
    if (rst) begin
      m_mode = 0; m_pc = 32'h0; m_v = 1'b0;
      m_instr = 32'h13; m_ipc = '0; m_ipc4 = '0;
      m_mis = 1'b0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (redirect_valid) begin
      m_pc = redirect_target & 32'hFFFF_FFFC;
      m_mis = (redirect_target % 4) != 0;
      m_v = 1'b0;
      m_mode = 1;
    end else if (m_mode == 2) begin
      m_v = 1'b0;
      if (resume) m_mode = 1;
    end else if (!stall) begin
      m_instr = mem_word(m_pc);
      m_ipc = m_pc;
      m_ipc4 = m_pc + 4;
      m_v = 1'b1;
      if (m_instr[6:0] == 7'h73) m_mode = 2;
      m_pc = m_pc + 4;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (chk_en) begin
        chk("m.imem_addr", imem_addr, m_pc);
        chk("m.id_valid", 32'(id_valid), 32'(m_v));
        chk("m.misalign", 32'(misalign), 32'(m_mis));
        chk("m.halted", 32'(halted), 32'(m_mode == 2));
        if (m_v) begin
          chk("m.id_instr", id_instr, m_instr);
          chk("m.id_opcode", 32'(id_opcode), 32'(m_instr[6:0]));
          chk("m.id_pc", id_pc, m_ipc);
          chk("m.id_pc_plus4", id_pc_plus4, m_ipc4);
        end
      end
    end
  end

  task automatic cyc(input logic r, input logic s, input logic rv,
                     input logic [31:0] t, input logic rs);
    @(negedge clk);
    rst = r; stall = s; redirect_valid = rv;
    redirect_target = t; resume = rs;
    @(posedge clk);
    model_step();
    if (r) chk_en = 1'b1;
    #3;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".valid"}, 32'(id_valid), 0);
    chk({tag, ".instr"}, id_instr, 32'h13);
    chk({tag, ".pc"}, id_pc, 0);
    chk({tag, ".pc4"}, id_pc_plus4, 0);
    chk({tag, ".mis"}, 32'(misalign), 0);
    chk({tag, ".halted"}, 32'(halted), 0);
    chk({tag, ".addr"}, imem_addr, 0);
  endtask

  initial begin
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk_reset("rst0");

    cyc(0, 0, 0, 0, 0);
    chk("boot.valid", 32'(id_valid), 0);
    chk("boot.addr", imem_addr, 0);
    run(1);
    chk("seq0.valid", 32'(id_valid), 1);
    chk("seq0.pc", id_pc, 0);
    run(1);
    chk("seq1.pc", id_pc, 4);
    cyc(0, 0, 0, 0, 1);
    chk("seq2.pc", id_pc, 8);
    chk("seq2.halted", 32'(halted), 0);

    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0, 0);
      chk("stall.pc", id_pc, 8);
      chk("stall.addr", imem_addr, 12);
    end
    run(1);
    chk("unstall.pc", id_pc, 12);
    run(1);
    chk("unstall.pc2", id_pc, 16);

    cyc(0, 1, 1, 32'h100, 0);
    chk("redir.valid", 32'(id_valid), 0);
    chk("redir.addr", imem_addr, 32'h100);
    run(1);
    chk("redir.pc", id_pc, 32'h100);

    cyc(0, 0, 1, 32'h102, 0);
    chk("mis.set", 32'(misalign), 1);
    chk("mis.addr", imem_addr, 32'h100);
    run(1);
    cyc(0, 0, 1, 32'h200, 0);
    chk("mis.clr", 32'(misalign), 0);

    cyc(0, 0, 1, 32'h18, 0);
    run(3);
    chk("ecall.valid", 32'(id_valid), 1);
    chk("ecall.pc", id_pc, 32'h20);
    chk("ecall.addr", imem_addr, 32'h24);
    cyc(0, 1, 0, 0, 0);
    chk("halt.valid", 32'(id_valid), 0);
    chk("halt.halted", 32'(halted), 1);
    chk("halt.addr", imem_addr, 32'h24);
    run(1);
    chk("halt.hold", imem_addr, 32'h24);
    cyc(0, 0, 0, 0, 1);
    chk("resume.halted", 32'(halted), 0);
    run(1);
    chk("resume.pc", id_pc, 32'h24);

    cyc(0, 0, 1, 32'hFFFF_FFFC, 0);
    run(1);
    chk("wrap.pc", id_pc, 32'hFFFF_FFFC);
    chk("wrap.pc4", id_pc_plus4, 0);
    chk("wrap.addr", imem_addr, 0);
    run(1);
    chk("wrap.next", id_pc, 0);

    cyc(1, 1, 0, 0, 0);
    chk_reset("rst_stall");
    run(1);
    chk("boot2.valid", 32'(id_valid), 0);
    run(1);
    chk("boot2.pc", id_pc, 0);

    cyc(0, 0, 1, 32'h1C, 0);
    run(2);
    chk("h2.halted", 32'(halted), 1);
    cyc(0, 0, 1, 32'h40, 0);
    chk("hredir.halted", 32'(halted), 0);
    chk("hredir.addr", imem_addr, 32'h40);
    run(1);
    chk("hredir.pc", id_pc, 32'h40);

    cyc(0, 0, 1, 32'h20, 0);
    run(2);
    chk("h3.halted", 32'(halted), 1);
    cyc(1, 1, 1, 32'h300, 1);
    chk_reset("rst_halt");
    run(2);
    chk("boot3.pc", id_pc, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
